// File: rtl/puf_resp_uart_tx.sv
// Snapshots the 128-bit PUF response on the rising edge of puf_done
// and sends it MSB byte first as 16 back-to-back UART 8N1 frames.
module puf_resp_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         puf_done,
  input  logic [127:0] puf_out,
  output logic         tx,
  output logic         busy,
  output logic         tx_done,
  output logic [3:0]   byte_idx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [127:0]  r_shreg;
  logic [3:0]    r_idx;
  logic          r_tx;
  logic          r_busy;
  logic          r_tx_done;
  logic          r_done_q;

  logic          w_trig;
  logic          w_bit_end;
  logic [7:0]    w_byte;

  assign w_trig    = puf_done & ~r_done_q;
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_byte    = r_shreg[127:120];

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign tx_done  = r_tx_done;
  assign byte_idx = r_idx;

  // tx is loaded with the level of the upcoming bit at each boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_idx     <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_done_q  <= puf_done;
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_trig) begin
            r_shreg <= puf_out;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= w_byte[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= w_byte[r_bit + 3'd1];
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shreg <= {r_shreg[119:0], 8'h00};
            if (r_idx == 4'd15) begin
              r_tx_done <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
